// File: rtl/toggle_rx_pkg.sv
// Shared definitions for the toggle-event receiver: FSM encoding and the
// legal synchronizer depth range.
package toggle_rx_pkg;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Arm counter must reach SYNC_STAGES_MAX+1
    localparam int unsigned ARM_CNT_W = 3;

    // Force a requested depth into the supported range
    function automatic int unsigned clamp_stages(input int unsigned n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/toggle_rx_sync.sv
// sync_chain: N-flop synchronizer with synchronous active-high reset.
//   clk : sampling clock
//   rst : synchronous reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] s;

    // Shift chain: s[0] samples d, s[N-1] is the stable output
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[N-2:0], d};
        end
    end

    assign q = s[N-1];

endmodule

// File: rtl/toggle_rx.sv
// toggle_rx: decodes a toggle-encoded event line into pulses and a
// saturating pending-event count drained through valid/ready.
//   clk       : clock
//   rst       : synchronous active-high reset
//   t_in      : toggle line, asynchronous to clk
//   ovf_clr   : clears the sticky overflow flag
//   evt_ready : consumer accepts one event
//   evt_valid : at least one event pending (decoded from pending)
//   pulse     : registered one-cycle strobe per detected transition
//   pending   : events not yet accepted (saturating)
//   total_cnt : events detected since reset (wrapping)
//   overflow  : sticky, set when an event was dropped
module toggle_rx
    import toggle_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             ovf_clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             pulse,
    output logic [CNT_W-1:0] pending,
    output logic [CNT_W-1:0] total_cnt,
    output logic             overflow
);

    localparam int unsigned N       = clamp_stages(SYNC_STAGES);
    localparam int unsigned ARM_LEN = N + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_next;
    logic [ARM_CNT_W-1:0] arm_cnt;
    logic                 s_last;
    logic                 prev;
    logic                 live_edge;
    logic                 accept;
    logic                 full;

    sync_chain #(.N(N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (t_in),
        .q   (s_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave ARM on the edge the counter reaches ARM_LEN
    always_comb begin
        state_next = state;
        case (state)
            ARM:     if (arm_cnt == ARM_CNT_W'(ARM_LEN - 1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = ARM;
        endcase
    end

    // Arm counter runs only in ARM, so it stops once RUN is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (state == ARM) begin
            arm_cnt <= arm_cnt + ARM_CNT_W'(1);
        end
    end

    // prev tracks the synchronized line in both states, so the level seen
    // at reset release is absorbed while the edge is masked
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= s_last;
            pulse <= live_edge;
        end
    end

    assign live_edge = (state == RUN) && (s_last ^ prev);
    assign evt_valid = (pending != '0);
    assign accept    = evt_valid && evt_ready;
    assign full      = (pending == CNT_MAX);

    // Pending count: simultaneous event and accept cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({pulse, accept})
                2'b10:   if (!full) pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Total count includes dropped events and wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            total_cnt <= '0;
        end else begin
            total_cnt <= total_cnt + CNT_W'(pulse);
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pulse && !accept && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx: default instance plus a CNT_W=3 instance
// for saturation.
module tb_toggle_rx;
    import toggle_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in, ovf_clr, evt_ready;
    logic       evt_valid, pulse, overflow;
    logic [7:0] pending, total_cnt;

    logic       t3, clr3, rdy3;
    logic       valid3, pulse3, ovf3;
    logic [2:0] pend3, tot3;

    int checks = 0;
    int errors = 0;

    toggle_rx dut (
        .clk(clk), .rst(rst), .t_in(t_in), .ovf_clr(ovf_clr),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .pulse(pulse),
        .pending(pending), .total_cnt(total_cnt), .overflow(overflow)
    );

    toggle_rx #(.SYNC_STAGES(2), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .t_in(t3), .ovf_clr(clr3),
        .evt_ready(rdy3), .evt_valid(valid3), .pulse(pulse3),
        .pending(pend3), .total_cnt(tot3), .overflow(ovf3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic       rdy;
        logic       clr;
        logic       exp_pulse;
        logic       exp_valid;
        logic [7:0] exp_pend;
        logic [7:0] exp_tot;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulse"}, int'(pulse), 0);
        chk({tag, "_valid"}, int'(evt_valid), 0);
        chk({tag, "_pending"}, int'(pending), 0);
        chk({tag, "_total"}, int'(total_cnt), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int npulse;
        int exp_p;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd2, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0};

        // Reset with the line already high
        rst = 1'b1; t_in = 1'b1; ovf_clr = 1'b0; evt_ready = 1'b0;
        t3 = 1'b0; clr3 = 1'b0; rdy3 = 1'b0;
        step(); step();
        chk_all_zero("reset");
        chk("reset_state", int'(dut.state), int'(ARM));
        rst = 1'b0;

        // Level at reset release must never become an event
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse) npulse++;
        end
        chk("armlevel_pulses", npulse, 0);
        chk("armlevel_pending", int'(pending), 0);
        chk("armlevel_total", int'(total_cnt), 0);
        chk("armlevel_state", int'(dut.state), int'(RUN));

        // Latency, handshake, simultaneous event+accept
        for (int i = 0; i < 16; i++) begin
            t_in = vecs[i].t; evt_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_pulse", i), int'(pulse), int'(vecs[i].exp_pulse));
            chk($sformatf("vec%0d_valid", i), int'(evt_valid), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pending", i), int'(pending), int'(vecs[i].exp_pend));
            chk($sformatf("vec%0d_total", i), int'(total_cnt), int'(vecs[i].exp_tot));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
        end
        ovf_clr = 1'b0; evt_ready = 1'b0;

        // Fresh reset, then fastest legal toggling with consumer always ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        evt_ready = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            t_in = ~t_in;
            step(); if (pulse) npulse++;
            step(); if (pulse) npulse++;
        end
        for (int i = 0; i < 6; i++) begin
            step(); if (pulse) npulse++;
        end
        chk("burst_pulses", npulse, 10);
        chk("burst_total", int'(total_cnt), 10);
        chk("burst_pending", int'(pending), 0);
        chk("burst_valid", int'(evt_valid), 0);

        // Build up 5 pending events
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            for (int j = 0; j < 4; j++) step();
        end
        chk("pend5_pending", int'(pending), 5);
        chk("pend5_valid", int'(evt_valid), 1);
        chk("pend5_total", int'(total_cnt), 15);

        // Mid-operation reset, with a toggle landing in the ARM window
        rst = 1'b1;
        t_in = ~t_in;
        step();
        chk_all_zero("midrst");
        chk("midrst_state", int'(dut.state), int'(ARM));
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse) npulse++;
        end
        chk("armtoggle_pulses", npulse, 0);
        chk("armtoggle_pending", int'(pending), 0);
        chk("armtoggle_total", int'(total_cnt), 0);

        // Saturation on the 3-bit instance
        for (int i = 1; i <= 8; i++) begin
            t3 = ~t3;
            for (int j = 0; j < 4; j++) step();
            exp_p = (i > 7) ? 7 : i;
            chk($sformatf("sat%0d_pending", i), int'(pend3), exp_p);
            chk($sformatf("sat%0d_ovf", i), int'(ovf3), (i == 8) ? 1 : 0);
            chk($sformatf("sat%0d_total", i), int'(tot3), i % 8);
        end
        chk("sat_valid", int'(valid3), 1);
        clr3 = 1'b1;
        step();
        clr3 = 1'b0;
        chk("satclr_ovf", int'(ovf3), 0);
        chk("satclr_pending", int'(pend3), 7);

        // Drop coinciding with ovf_clr: set wins
        t3 = ~t3;
        step(); step(); step();
        chk("prio_pulse", int'(pulse3), 1);
        clr3 = 1'b1;
        step();
        clr3 = 1'b0;
        chk("prio_ovf", int'(ovf3), 1);
        chk("prio_pending", int'(pend3), 7);
        chk("prio_total", int'(tot3), 1);

        // Drain one event from the saturated counter
        rdy3 = 1'b1;
        step();
        rdy3 = 1'b0;
        chk("drain_pending", int'(pend3), 6);
        chk("drain_ovf", int'(ovf3), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_rx.md
# toggle_rx

Receive-side decoder for toggle-encoded event signalling. A sending domain flips one line once per event, typically from a T flip-flop. This block synchronizes that line into `clk`, turns each transition back into a single-cycle pulse, and queues the events as a saturating count. A consumer drains the count through a valid/ready handshake. The block sits at the clock-domain boundary, directly downstream of the sender's toggle flop.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth; legal range 2–4.
- `CNT_W`, default 8: width of the pending and total counters.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `t_in` in 1: toggle line; asynchronous to `clk`.
- `ovf_clr` in 1: clears the sticky `overflow` flag.
- `evt_ready` in 1: consumer accepts one event this cycle.
- `evt_valid` out 1: at least one event is pending.
- `pulse` out 1: one-cycle strobe per detected transition, registered.
- `pending` out CNT_W: events not yet accepted.
- `total_cnt` out CNT_W: events detected since reset; wraps modulo 2^CNT_W.
- `overflow` out 1: sticky; set when an event was dropped.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops, s[0]..s[N-1], on `t_in`. A `prev` flop holds the previous value of s[N-1].
- Edge detection: `edge = s[N-1] ^ prev`. Rising and falling transitions both count as one event.
- State machine, two states:
  - ARM (entered on reset): the arm counter counts `SYNC_STAGES+1` cycles. `prev` follows s[N-1]. `edge` is masked.
  - ARM → RUN when the arm counter reaches `SYNC_STAGES+1`.
  - RUN: `edge` is live. There is no exit from RUN except `rst`.
- Effect of the ARM state: the line level present at reset release never produces an event.
- `pulse` is the registered `edge` (RUN only).
- `pending` update:
  - +1 when `pulse` is high.
  - −1 when `evt_valid && evt_ready`.
  - Both in the same cycle: net unchanged.
- Saturation: when `pending == 2^CNT_W−1`, `pulse` is high and no accept occurs, the event is dropped, `pending` holds, and `overflow` sets.
- `evt_valid` is `pending != 0`, decoded combinationally from the register.
- `evt_ready` while `evt_valid` is low is ignored; `pending` never underflows.
- `total_cnt` increments on every `pulse`, including dropped events, and wraps to 0.
- `overflow` update:
  - Cleared by `ovf_clr`.
  - A set in the same cycle as `ovf_clr` takes priority, so the flag stays 1.
- Reset behaviour:
  - `rst` clears all synchronizer flops, `prev`, the arm counter, `pulse`, `pending`, `total_cnt` and `overflow` to 0, and forces ARM.
  - Reset mid-operation discards all pending events.

## Timing
- Reset values of outputs: `pulse`=0, `evt_valid`=0, `pending`=0, `total_cnt`=0, `overflow`=0.
- Latency: number the first edge that samples a new `t_in` level as edge 1. `pulse` is high for exactly one cycle after edge `SYNC_STAGES+1`; with default parameters that is after edge 3.
- `pending` and `total_cnt` update on the edge after `pulse` is seen high, i.e. one cycle after `pulse`.
- Handshake: the accept takes effect on the rising edge where `evt_valid && evt_ready`. `evt_valid` drops in the next cycle only if `pending` was 1 and no simultaneous event arrived.
- Sender constraint: each `t_in` level must be held for at least 2 `clk` periods. Faster toggling is outside spec and may lose events.
- ARM lasts `SYNC_STAGES+1` cycles after `rst` falls. A transition arriving during ARM is absorbed, not counted.

## Structure
- Shared package `toggle_rx_pkg` holds:
  - the state encoding (ARM=1'b0, RUN=1'b1);
  - the min/max bounds for `SYNC_STAGES` (2/4).
- Sub-module `sync_chain`: parameterized N-flop synchronizer with synchronous reset, reusable elsewhere. `toggle_rx` instantiates it once.
- The top level holds `prev`, the arm counter, the FSM and the counters.

## Test plan
- Hold `t_in`=1 through reset, then release and hold 20 cycles → `pulse` never high, `pending`=0, `total_cnt`=0.
- Defaults; after ARM, change `t_in` 0→1 sampled at edge k → `pulse` high only in the cycle after edge k+2. Then `pending`=1 and `evt_valid`=1. One cycle of `evt_ready` → `pending`=0.
- `pending`=1; `pulse` and `evt_ready` high in the same cycle → `pending` stays 1 and `evt_valid` stays 1.
- `CNT_W`=3, `evt_ready`=0; 8 toggles spaced 4 cycles apart → `pending` saturates at 7, `overflow`=1 after the 8th, `total_cnt`=0. Pulse `ovf_clr` → `overflow`=0 and `pending`=7.
- Toggle every 2 cycles, 10 times, with `evt_ready`=1 → exactly 10 `pulse`s, `total_cnt`=10, `pending` returns to 0.
- `pending`=5 and FSM in RUN; assert `rst` for 1 cycle → all outputs 0 on the next edge and the FSM in ARM. A toggle during the following ARM window is not counted.
